// File: rtl/rc_pwm_capture.sv
// Multi-channel hobby-RC PWM pulse-width capture.
// Each channel measures the high time of its input in prescaled ticks, drops
// glitches, saturates long pulses into an error, and falls back to a failsafe
// value when the signal is lost or capture is disabled. All channels share one
// tick prescaler and are otherwise independent.
module rc_pwm_capture #(
   parameter int               NUM_CH        = 4,
   parameter int               OUT_W         = 8,
   parameter int               CLK_DIV       = 208,
   parameter int               MIN_TICKS     = 256,
   parameter int               GLITCH_TICKS  = 128,
   parameter int               MAX_TICKS     = 768,
   parameter int               TIMEOUT_TICKS = 6400,
   parameter logic [OUT_W-1:0] FAILSAFE      = '0
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        pwm_in,
   output logic [NUM_CH*OUT_W-1:0]  pwm_out,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic [NUM_CH-1:0]        new_sample
);

   localparam int HC_W = OUT_W + 2;
   localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
   localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(CLK_DIV - 1);
   localparam logic [HC_W-1:0] GLITCH_C  = HC_W'(GLITCH_TICKS);
   localparam logic [HC_W-1:0] MIN_C     = HC_W'(MIN_TICKS);
   localparam logic [HC_W-1:0] MAX_C     = HC_W'(MAX_TICKS);
   localparam logic [TO_W-1:0] TO_C      = TO_W'(TIMEOUT_TICKS);

   typedef enum logic [1:0] {
      ST_WAIT_LOW = 2'd0,
      ST_LOW      = 2'd1,
      ST_HIGH     = 2'd2
   } ch_state_e;

   logic [NUM_CH-1:0] sync1_q, sync2_q, hist_q;
   logic [1:0]        primed_q;
   logic [PS_W-1:0]   ps_q, ps_d;
   logic              tick;

   // Two-flop synchroniser plus history flop per input; primed_q marks when
   // sync2_q first holds a real input sample rather than its reset value.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      // NOTE: state is always assigned with <= so every flop samples the
      // pre-edge value of its neighbours and the pipeline shifts one stage.
      if (!sys_rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         hist_q   <= '0;
         primed_q <= '0;
      end else begin
         sync1_q  <= pwm_in;
         sync2_q  <= sync1_q;
         hist_q   <= sync2_q;
         primed_q <= {primed_q[0], 1'b1};
      end
   end

   // Shared prescaler: counts down, reloads after reaching zero, parked while disabled.
   always_comb begin
      // NOTE: ps_d gets a value on every path first, so no latch is inferred.
      ps_d = ps_q;
      if (!enable || (ps_q == '0)) ps_d = PS_RELOAD;
      else                         ps_d = ps_q - PS_W'(1);
   end

   // Prescaler register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) ps_q <= PS_RELOAD;
      else            ps_q <= ps_d;
   end

   assign tick = enable && (ps_q == '0);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ch_state_e        state_q, state_d;
      logic [HC_W-1:0]  hc_q, hc_d;
      logic [TO_W-1:0]  to_q, to_d;
      logic [OUT_W-1:0] out_q, out_d;
      logic             valid_q, valid_d;
      logic             ns_q, ns_d;
      logic             level, rise, fall, hc_max, timeout;
      logic [HC_W-1:0]  diff;
      logic [OUT_W-1:0] scaled;

      assign level   = sync2_q[g];
      assign rise    = sync2_q[g] & ~hist_q[g];
      assign fall    = ~sync2_q[g] & hist_q[g];
      assign hc_max  = (hc_q >= MAX_C);
      assign timeout = (to_q >= TO_C);

      // Offset by one millisecond, floor at zero, clamp to full scale.
      assign diff   = hc_q - MIN_C;
      assign scaled = (hc_q < MIN_C)           ? '0 :
                      (|diff[HC_W-1:OUT_W])    ? '1 : diff[OUT_W-1:0];

      // Channel state register.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) state_q <= ST_WAIT_LOW;
         else            state_q <= state_d;
      end

      // Next state: wait for a real low, then track rise/fall; overlong pulses abort.
      always_comb begin
         state_d = state_q;
         if (!enable) begin
            state_d = ST_WAIT_LOW;
         end else begin
            unique case (state_q)
               ST_WAIT_LOW: if (primed_q[1] && !level) state_d = ST_LOW;
               ST_LOW:      if (rise)                  state_d = ST_HIGH;
               ST_HIGH: begin
                  if (hc_max)    state_d = ST_WAIT_LOW;
                  else if (fall) state_d = ST_LOW;
               end
               default:         state_d = ST_WAIT_LOW;
            endcase
         end
      end

      // Counters and outputs: timeout loss first, then the event of this state.
      always_comb begin
         hc_d    = hc_q;
         to_d    = to_q;
         out_d   = out_q;
         valid_d = valid_q;
         ns_d    = 1'b0;
         if (!enable) begin
            hc_d    = '0;
            to_d    = '0;
            out_d   = FAILSAFE;
            valid_d = 1'b0;
         end else begin
            if (tick && (state_q != ST_WAIT_LOW) && (to_q != '1)) to_d = to_q + TO_W'(1);
            if (timeout) begin
               out_d   = FAILSAFE;
               valid_d = 1'b0;
            end
            unique case (state_q)
               ST_LOW: if (rise) hc_d = '0;
               ST_HIGH: begin
                  if (hc_max) begin
                     out_d   = FAILSAFE;
                     valid_d = 1'b0;
                  end else if (fall) begin
                     if (hc_q >= GLITCH_C) begin
                        out_d   = scaled;
                        valid_d = 1'b1;
                        ns_d    = 1'b1;
                        to_d    = '0;
                     end
                  end else if (tick && (hc_q != '1)) begin
                     hc_d = hc_q + HC_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end

      // Channel datapath registers.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            hc_q    <= '0;
            to_q    <= '0;
            out_q   <= FAILSAFE;
            valid_q <= 1'b0;
            ns_q    <= 1'b0;
         end else begin
            hc_q    <= hc_d;
            to_q    <= to_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ns_q    <= ns_d;
         end
      end

      assign pwm_out[g*OUT_W +: OUT_W] = out_q;
      assign ch_valid[g]               = valid_q;
      assign new_sample[g]             = ns_q;
   end

endmodule

// File: tb/tb_rc_pwm_capture.sv
// Directed bench for rc_pwm_capture with a fast prescaler (4 clocks per tick).
// Pulses are launched one clock after a tick edge so a pulse of N ticks
// measures exactly N.
module tb_rc_pwm_capture;

   localparam int NUM_CH  = 4;
   localparam int OUT_W   = 8;
   localparam int CLK_DIV = 4;

   logic                    sys_clk   = 1'b0;
   logic                    sys_rst_n = 1'b0;
   logic                    enable    = 1'b1;
   logic [NUM_CH-1:0]       pwm_in    = '0;
   logic [NUM_CH*OUT_W-1:0] pwm_out;
   logic [NUM_CH-1:0]       ch_valid;
   logic [NUM_CH-1:0]       new_sample;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc   = 0;
   int         sc[NUM_CH] = '{default: 0};
   logic [1:0] ph    = 2'd3;
   int         t_fall;
   int         tot0;

   rc_pwm_capture #(.CLK_DIV(CLK_DIV)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .enable     (enable),
      .pwm_in     (pwm_in),
      .pwm_out    (pwm_out),
      .ch_valid   (ch_valid),
      .new_sample (new_sample)
   );

   always #5 sys_clk = ~sys_clk;

   // Cycle counter (value after edge k is k).
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Tick phase reference: 3 means the next tick edge is four edges away.
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)   ph <= 2'd3;
      else if (!enable) ph <= 2'd3;
      else              ph <= (ph == 2'd0) ? 2'd3 : ph - 2'd1;
   end

   // Strobe counters per channel.
   always @(negedge sys_clk) begin
      for (int i = 0; i < NUM_CH; i++)
         if (new_sample[i]) sc[i] <= sc[i] + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic align();
      int k = 0;
      @(negedge sys_clk);
      while (!(ph == 2'd3 && enable)) begin
         @(negedge sys_clk);
         k++;
         if (k > 16) begin
            n_cmp++;
            n_err++;
            $display("FAIL align: tick phase not found within 16 clocks");
            break;
         end
      end
   endtask

   task automatic pulse(input logic [NUM_CH-1:0] mask, input int ticks);
      align();
      pwm_in = pwm_in | mask;
      repeat (CLK_DIV * ticks) @(negedge sys_clk);
      pwm_in = pwm_in & ~mask;
   endtask

   task automatic gap(input int ticks);
      repeat (CLK_DIV * ticks) @(negedge sys_clk);
   endtask

   task automatic settle();
      repeat (4) @(posedge sys_clk);
      #1;
   endtask

   task automatic expect_ch0(input string tag, input logic [7:0] e_out,
                             input logic e_valid, input int e_cnt);
      settle();
      chk({tag, "_out"},   32'(pwm_out[7:0]), 32'(e_out));
      chk({tag, "_valid"}, 32'(ch_valid[0]),  32'(e_valid));
      chk({tag, "_cnt"},   32'(sc[0]),        32'(e_cnt));
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge sys_clk);
      chk("rst_out",   pwm_out,           32'h0);
      chk("rst_valid", 32'(ch_valid),     32'h0);
      chk("rst_ns",    32'(new_sample),   32'h0);
      sys_rst_n = 1'b1;
      gap(10);

      // 1.5 ms on ch0 with latency of the strobe
      pulse(4'b0001, 384);
      @(posedge sys_clk); #1;
      chk("lat_e1_ns", 32'(new_sample), 32'h0);
      @(posedge sys_clk); #1;
      chk("lat_e2_ns", 32'(new_sample), 32'h0);
      @(posedge sys_clk); #1;
      chk("lat_e3_ns",    32'(new_sample),  32'h1);
      chk("lat_e3_out",   32'(pwm_out[7:0]), 32'd128);
      chk("lat_e3_valid", 32'(ch_valid),   32'h1);
      @(posedge sys_clk); #1;
      chk("lat_e4_ns", 32'(new_sample), 32'h0);
      gap(300);
      pulse(4'b0001, 384);
      expect_ch0("p1500b", 8'd128, 1'b1, 2);

      // Range: floor, clamp, just-below-max, errors
      gap(100); pulse(4'b0001, 205); expect_ch0("p0800",  8'd0,   1'b1, 3);
      gap(100); pulse(4'b0001, 563); expect_ch0("p2200",  8'd255, 1'b1, 4);
      gap(100); pulse(4'b0001, 767); expect_ch0("p767",   8'd255, 1'b1, 5);
      gap(100); pulse(4'b0001, 819); expect_ch0("p3200",  8'd0,   1'b0, 5);
      gap(100); pulse(4'b0001, 320); expect_ch0("rec1",   8'd64,  1'b1, 6);
      gap(100); pulse(4'b0001, 768); expect_ch0("p768",   8'd0,   1'b0, 6);

      // Glitch rejection around the threshold
      gap(100); pulse(4'b0001, 320); expect_ch0("p1250a", 8'd64,  1'b1, 7);
      gap(100); pulse(4'b0001, 77);  expect_ch0("gl77",   8'd64,  1'b1, 7);
      gap(100); pulse(4'b0001, 127); expect_ch0("gl127",  8'd64,  1'b1, 7);
      gap(100); pulse(4'b0001, 128); expect_ch0("p128",   8'd0,   1'b1, 8);
      gap(100); pulse(4'b0001, 320); expect_ch0("p1250b", 8'd64,  1'b1, 9);

      // Loss of signal on ch2 while the other channels keep pulsing
      gap(100);
      pulse(4'b1111, 320);
      t_fall = cyc;
      settle();
      chk("all_out",   pwm_out,       32'h4040_4040);
      chk("all_valid", 32'(ch_valid), 32'hf);
      gap(2000); pulse(4'b1011, 320);
      gap(2000); pulse(4'b1011, 320);
      chk("to_window", 32'(cyc < t_fall + 25600), 32'h1);
      while (cyc < t_fall + 25600) begin
         @(posedge sys_clk); #1;
      end
      chk("to_pre_valid", 32'(ch_valid), 32'hf);
      chk("to_pre_out",   pwm_out,       32'h4040_4040);
      @(posedge sys_clk); #1;
      chk("to_post_valid", 32'(ch_valid), 32'hb);
      chk("to_post_out",   pwm_out,       32'h4000_4040);
      gap(50);
      pulse(4'b1111, 320);
      settle();
      chk("resume_valid", 32'(ch_valid), 32'hf);
      chk("resume_out",   pwm_out,       32'h4040_4040);
      chk("resume_cnt2",  32'(sc[2]),    32'd2);

      // Asynchronous reset mid-pulse, released while the line is still high
      gap(50);
      align();
      pwm_in = 4'b1111;
      repeat (400) @(negedge sys_clk);
      chk("prerst_valid", 32'(ch_valid), 32'hf);
      tot0 = sc[0] + sc[1] + sc[2] + sc[3];
      #2 sys_rst_n = 1'b0;
      #1;
      chk("arst_out",   pwm_out,         32'h0);
      chk("arst_valid", 32'(ch_valid),   32'h0);
      chk("arst_ns",    32'(new_sample), 32'h0);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (800) @(negedge sys_clk);
      pwm_in = 4'b0000;
      repeat (20) @(negedge sys_clk);
      chk("postrst_cnt",   32'(sc[0] + sc[1] + sc[2] + sc[3]), 32'(tot0));
      chk("postrst_valid", 32'(ch_valid), 32'h0);
      gap(50);
      pulse(4'b1111, 384);
      settle();
      chk("postrst_out",    pwm_out,       32'h8080_8080);
      chk("postrst_valid2", 32'(ch_valid), 32'hf);

      // Enable dropped for 10 clocks mid-pulse
      gap(50);
      align();
      pwm_in = 4'b1111;
      repeat (400) @(negedge sys_clk);
      tot0 = sc[0] + sc[1] + sc[2] + sc[3];
      enable = 1'b0;
      @(posedge sys_clk); #1;
      chk("dis_valid", 32'(ch_valid), 32'h0);
      chk("dis_out",   pwm_out,       32'h0);
      repeat (10) @(negedge sys_clk);
      enable = 1'b1;
      repeat (1200) @(negedge sys_clk);
      pwm_in = 4'b0000;
      repeat (20) @(negedge sys_clk);
      chk("reen_cnt",   32'(sc[0] + sc[1] + sc[2] + sc[3]), 32'(tot0));
      chk("reen_valid", 32'(ch_valid), 32'h0);
      chk("reen_out",   pwm_out,       32'h0);
      gap(50);
      pulse(4'b1111, 448);
      settle();
      chk("reen_full_out",   pwm_out,       32'hc0c0_c0c0);
      chk("reen_full_valid", 32'(ch_valid), 32'hf);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
